// File: rtl/multicycle_exec_unit_if.sv
// Valid/ready handshake bundle for the multicycle execute stage: operand/instruction
// request channel, result channel, and the combinational immediate.
interface multicycle_exec_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instruction;
   logic            alu_src;
   logic [1:0]      alu_oper;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            is_zero;
   logic            illegal;
   logic [XLEN-1:0] ext_imm;

   modport master (
      output in_valid, instruction, alu_src, alu_oper, rs1_val, rs2_val, out_ready,
      input  in_ready, out_valid, result, is_zero, illegal, ext_imm
   );

   modport slave (
      input  in_valid, instruction, alu_src, alu_oper, rs1_val, rs2_val, out_ready,
      output in_ready, out_valid, result, is_zero, illegal, ext_imm
   );
endinterface

// File: rtl/multicycle_exec_unit.sv
// Execute stage: single-cycle RV32I-style integer ops plus iterative MUL/MULHU/DIVU/REMU
// (one shift-add or restoring shift-subtract step per cycle), valid/ready on both sides.
module multicycle_exec_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_exec_unit_if.slave bus
);

   localparam int unsigned SHW = $clog2(XLEN);
   localparam int unsigned CW  = SHW + 1;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   typedef enum logic [1:0] {MOP_MUL, MOP_MULHU, MOP_DIVU, MOP_REMU} mop_e;

   state_e            state_q, state_d;
   mop_e              mop_q, mop_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              is_zero_q, is_zero_d;
   logic              illegal_q, illegal_d;
   logic              out_valid_q, out_valid_d;
   logic [CW-1:0]     count_q, count_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opa_q, opa_d;
   logic [XLEN-1:0]   opb_q, opb_d;

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic signed [31:0] imm32;
   logic [XLEN-1:0]   ext_imm;
   logic [XLEN-1:0]   op1, op2;
   logic [SHW-1:0]    shamt;
   logic [XLEN-1:0]   alu_res;
   logic              alu_ill;
   logic              is_mop;
   mop_e              mop_sel;
   logic              in_ready;
   logic              accept;
   logic              unused_fields;

   assign opcode        = bus.instruction[6:0];
   assign funct3        = bus.instruction[14:12];
   assign funct7        = bus.instruction[31:25];
   assign unused_fields = ^bus.instruction[19:15];

   always_comb begin
      imm32 = '0;
      case (opcode)
         OPC_OP_IMM, OPC_LOAD: imm32 = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
         OPC_STORE:  imm32 = {{20{bus.instruction[31]}}, bus.instruction[31:25],
                              bus.instruction[11:7]};
         OPC_BRANCH: imm32 = {{20{bus.instruction[31]}}, bus.instruction[7],
                              bus.instruction[30:25], bus.instruction[11:8], 1'b0};
         default:    imm32 = '0;
      endcase
   end

   assign ext_imm = XLEN'(imm32);
   assign op1     = bus.rs1_val;
   assign op2     = bus.alu_src ? ext_imm : bus.rs2_val;
   assign shamt   = op2[SHW-1:0];

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      is_mop  = 1'b0;
      mop_sel = MOP_MUL;
      case (bus.alu_oper)
         2'b00: alu_res = op1 + op2;
         2'b01: alu_res = op1 - op2;
         2'b10: begin
            if (opcode == OPC_OP && funct7 == 7'b0000001) begin
               is_mop = 1'b1;
               case (funct3)
                  3'b000:  mop_sel = MOP_MUL;
                  3'b011:  mop_sel = MOP_MULHU;
                  3'b101:  mop_sel = MOP_DIVU;
                  3'b111:  mop_sel = MOP_REMU;
                  default: begin
                     is_mop  = 1'b0;
                     alu_ill = 1'b1;
                  end
               endcase
            end else if (opcode == OPC_OP_IMM || opcode == OPC_OP) begin
               case (funct3)
                  3'b000: alu_res = (opcode == OPC_OP && funct7[5]) ? op1 - op2 : op1 + op2;
                  3'b001: alu_res = op1 << shamt;
                  3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
                  3'b011: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
                  3'b100: alu_res = op1 ^ op2;
                  3'b101: alu_res = funct7[5] ? XLEN'($signed(op1) >>> shamt) : op1 >> shamt;
                  3'b110: alu_res = op1 | op2;
                  default: alu_res = op1 & op2;
               endcase
            end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
               alu_res = op1 + op2;
            end else if (opcode == OPC_BRANCH) begin
               alu_res = op1 - op2;
            end else begin
               alu_ill = 1'b1;
            end
         end
         default: alu_res = '0;
      endcase
   end

   // Multiply: acc high half accumulates, product shifts right into the low half.
   // Divide: acc = {remainder, quotient}; opb shifts the dividend out MSB-first.
   logic              is_div_q;
   logic [XLEN-1:0]   mul_addend;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_trial;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] step_acc;
   logic [XLEN-1:0]   step_res;

   assign is_div_q   = (mop_q == MOP_DIVU) || (mop_q == MOP_REMU);
   assign mul_addend = opb_q[0] ? opa_q : '0;
   assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
   assign div_trial  = {acc_q[2*XLEN-1:XLEN], opb_q[XLEN-1]} - {1'b0, opa_q};
   assign div_rem    = div_trial[XLEN] ? {acc_q[2*XLEN-2:XLEN], opb_q[XLEN-1]}
                                       : div_trial[XLEN-1:0];
   assign step_acc   = is_div_q ? {div_rem, acc_q[XLEN-2:0], ~div_trial[XLEN]}
                                : {mul_sum, acc_q[XLEN-1:1]};
   assign step_res   = (mop_q == MOP_MUL || mop_q == MOP_DIVU) ? step_acc[XLEN-1:0]
                                                               : step_acc[2*XLEN-1:XLEN];

   assign in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      mop_d       = mop_q;
      result_d    = result_q;
      is_zero_d   = is_zero_q;
      illegal_d   = illegal_q;
      out_valid_d = out_valid_q;
      count_d     = count_q;
      acc_d       = acc_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      case (state_q)
         BUSY: begin
            acc_d   = step_acc;
            opb_d   = is_div_q ? opb_q << 1 : opb_q >> 1;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               illegal_d   = 1'b0;
               result_d    = step_res;
               is_zero_d   = (step_res == '0);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // Accept overrides the DONE retire path so an op can be taken on the retire edge.
      if (accept) begin
         illegal_d = 1'b0;
         if (is_mop && (mop_sel == MOP_DIVU || mop_sel == MOP_REMU) && op2 == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = (mop_sel == MOP_REMU) ? op1 : '1;
            is_zero_d   = (mop_sel == MOP_REMU) && (op1 == '0);
         end else if (is_mop) begin
            state_d     = BUSY;
            out_valid_d = 1'b0;
            mop_d       = mop_sel;
            acc_d       = '0;
            count_d     = CW'(XLEN);
            opa_d       = (mop_sel == MOP_DIVU || mop_sel == MOP_REMU) ? op2 : op1;
            opb_d       = (mop_sel == MOP_DIVU || mop_sel == MOP_REMU) ? op1 : op2;
         end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = alu_res;
            is_zero_d   = (alu_res == '0);
            illegal_d   = alu_ill;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mop_q       <= MOP_MUL;
         result_q    <= '0;
         is_zero_q   <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
         count_q     <= '0;
         acc_q       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
      end else begin
         state_q     <= state_d;
         mop_q       <= mop_d;
         result_q    <= result_d;
         is_zero_q   <= is_zero_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.is_zero   = is_zero_q;
   assign bus.illegal   = illegal_q;
   assign bus.ext_imm   = ext_imm;

endmodule

// File: tb/tb_multicycle_exec_unit.sv
// Bench for multicycle_exec_unit: directed and random ops on a 32-bit and a 16-bit
// instance, checked against an arithmetic reference model.
module tb_multicycle_exec_unit;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        sel;
   logic        d_valid, d_src, d_oready;
   logic [31:0] d_instr, d_rs1, d_rs2;
   logic [1:0]  d_oper;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   multicycle_exec_unit_if #(.XLEN(32)) bus32 ();
   multicycle_exec_unit_if #(.XLEN(16)) bus16 ();

   multicycle_exec_unit #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
   multicycle_exec_unit #(.XLEN(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

   assign bus32.in_valid    = d_valid && !sel;
   assign bus32.instruction = d_instr;
   assign bus32.alu_src     = d_src;
   assign bus32.alu_oper    = d_oper;
   assign bus32.rs1_val     = d_rs1;
   assign bus32.rs2_val     = d_rs2;
   assign bus32.out_ready   = d_oready;
   assign bus16.in_valid    = d_valid && sel;
   assign bus16.instruction = d_instr;
   assign bus16.alu_src     = d_src;
   assign bus16.alu_oper    = d_oper;
   assign bus16.rs1_val     = d_rs1[15:0];
   assign bus16.rs2_val     = d_rs2[15:0];
   assign bus16.out_ready   = d_oready;

   logic [31:0] o_result, o_ext;
   logic        o_valid, o_ready, o_zero, o_ill;
   always_comb begin
      if (sel) begin
         o_result = {16'h0, bus16.result};
         o_ext    = {16'h0, bus16.ext_imm};
         o_valid  = bus16.out_valid;
         o_ready  = bus16.in_ready;
         o_zero   = bus16.is_zero;
         o_ill    = bus16.illegal;
      end else begin
         o_result = bus32.result;
         o_ext    = bus32.ext_imm;
         o_valid  = bus32.out_valid;
         o_ready  = bus32.in_ready;
         o_zero   = bus32.is_zero;
         o_ill    = bus32.illegal;
      end
   end

   logic [31:0] exp_res, exp_imm;
   logic        exp_ill;
   int          exp_lat;
   string       cur_tag;

   function automatic int width();
      return sel ? 16 : 32;
   endfunction

   function automatic logic [31:0] mask(input int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      return m[31:0];
   endfunction

   function automatic longint sval(input logic [63:0] v, input int w);
      if (v[w-1]) return longint'(v) - (longint'(1) << w);
      return longint'(v);
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] ins, input int w);
      logic [63:0] f;
      longint      v;
      v = 0;
      case (ins[6:0])
         7'h13, 7'h03: begin f = {52'h0, ins[31:20]};              v = sval(f, 12); end
         7'h23:        begin f = {52'h0, ins[31:25], ins[11:7]};   v = sval(f, 12); end
         7'h63: begin
            f = {51'h0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            v = sval(f, 13);
         end
         default: v = 0;
      endcase
      return 32'(v) & mask(w);
   endfunction

   function automatic void ref_exec(input logic [31:0] ins, input logic src,
                                    input logic [1:0] oper, input logic [31:0] ra,
                                    input logic [31:0] rb, input int w,
                                    output logic [31:0] res, output logic ill,
                                    output int lat);
      string       op;
      logic [63:0] a, b, m, r;
      int          sh;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      m   = {32'h0, mask(w)};
      a   = {32'h0, ra} & m;
      b   = (src ? {32'h0, ref_imm(ins, w)} : {32'h0, rb}) & m;
      sh  = int'(b % 64'(w));
      op  = "illegal";
      case (oper)
         2'd0: op = "add";
         2'd1: op = "sub";
         2'd3: op = "zero";
         default: begin
            if (opc == 7'h33 && f7 == 7'd1) begin
               case (f3)
                  3'd0: op = "mul";
                  3'd3: op = "mulhu";
                  3'd5: op = "divu";
                  3'd7: op = "remu";
                  default: op = "illegal";
               endcase
            end else if (opc == 7'h13 || opc == 7'h33) begin
               case (f3)
                  3'd0: op = (opc == 7'h33 && f7[5]) ? "sub" : "add";
                  3'd1: op = "sll";
                  3'd2: op = "slt";
                  3'd3: op = "sltu";
                  3'd4: op = "xor";
                  3'd5: op = f7[5] ? "sra" : "srl";
                  3'd6: op = "or";
                  default: op = "and";
               endcase
            end else if (opc == 7'h03 || opc == 7'h23) op = "add";
            else if (opc == 7'h63) op = "sub";
         end
      endcase
      ill = (op == "illegal");
      lat = 1;
      case (op)
         "add":   r = a + b;
         "sub":   r = a - b;
         "sll":   r = a << sh;
         "srl":   r = a >> sh;
         "sra":   r = 64'(sval(a, w) >>> sh);
         "slt":   r = (sval(a, w) < sval(b, w)) ? 64'd1 : 64'd0;
         "sltu":  r = (a < b) ? 64'd1 : 64'd0;
         "xor":   r = a ^ b;
         "or":    r = a | b;
         "and":   r = a & b;
         "mul":   begin r = a * b;        lat = w + 1; end
         "mulhu": begin r = (a * b) >> w; lat = w + 1; end
         "divu": begin
            if (b == 0) r = m;
            else begin r = a / b; lat = w + 1; end
         end
         "remu": begin
            if (b == 0) r = a;
            else begin r = a % b; lat = w + 1; end
         end
         default: r = 0;
      endcase
      res = r[31:0] & m[31:0];
   endfunction

   function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h33};
   endfunction

   function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [6:0] opc);
      return {imm, 5'd1, f3, 5'd3, opc};
   endfunction

   function automatic logic [31:0] mk_s(input logic [11:0] imm);
      return {imm[11:5], 5'd2, 5'd1, 3'b010, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] mk_b(input logic [12:0] imm);
      return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'h63};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic present(input string tag, input logic [31:0] ins, input logic src,
                          input logic [1:0] oper, input logic [31:0] a,
                          input logic [31:0] b, input logic ordy);
      ref_exec(ins, src, oper, a, b, width(), exp_res, exp_ill, exp_lat);
      exp_imm = ref_imm(ins, width());
      cur_tag = tag;
      @(negedge clk);
      d_instr  = ins;
      d_src    = src;
      d_oper   = oper;
      d_rs1    = a;
      d_rs2    = b;
      d_valid  = 1'b1;
      d_oready = ordy;
      #1;
      chk({tag, "/in_ready"}, 32'(o_ready), 32'd1);
      chk({tag, "/ext_imm"}, o_ext, exp_imm);
   endtask

   // Scrambles the inputs after accept: captured operands must be unaffected.
   task automatic collect();
      int lat;
      int bound;
      lat   = 0;
      bound = 2 * width() + 8;
      @(posedge clk);
      #1;
      d_valid = 1'b0;
      d_instr = $urandom;
      d_rs1   = $urandom;
      d_rs2   = $urandom;
      d_src   = 1'($urandom);
      d_oper  = 2'($urandom);
      for (int k = 1; k <= bound; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         if (o_valid) begin
            lat = k;
            break;
         end
      end
      chk({cur_tag, "/latency"}, 32'(lat), 32'(exp_lat));
      chk({cur_tag, "/result"}, o_result, exp_res);
      chk({cur_tag, "/is_zero"}, 32'(o_zero), 32'(exp_res == 32'd0));
      chk({cur_tag, "/illegal"}, 32'(o_ill), 32'(exp_ill));
   endtask

   task automatic run_op(input string tag, input logic [31:0] ins, input logic src,
                         input logic [1:0] oper, input logic [31:0] a, input logic [31:0] b);
      present(tag, ins, src, oper, a, b, 1'b1);
      collect();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_suite();
      logic [31:0] m, msb, prev, held;
      m   = mask(width());
      msb = 32'h1 << (width() - 1);
      run_op("addi",     mk_i(12'hFFD, 3'd0, 7'h13), 1'b1, 2'b10, 32'd5, 32'd0);
      run_op("sra",      mk_r(7'h20, 3'd5), 1'b0, 2'b10, msb, 32'd4);
      run_op("srl",      mk_r(7'h00, 3'd5), 1'b0, 2'b10, msb, 32'd4);
      run_op("sltu",     mk_r(7'h00, 3'd3), 1'b0, 2'b10, 32'd1, m);
      run_op("slt",      mk_r(7'h00, 3'd2), 1'b0, 2'b10, 32'd1, m);
      run_op("mulhu",    mk_r(7'h01, 3'd3), 1'b0, 2'b10, m, m);
      run_op("mul",      mk_r(7'h01, 3'd0), 1'b0, 2'b10, m, m);
      run_op("divu",     mk_r(7'h01, 3'd5), 1'b0, 2'b10, 32'd100, 32'd7);
      run_op("remu",     mk_r(7'h01, 3'd7), 1'b0, 2'b10, 32'd100, 32'd7);
      run_op("divu0",    mk_r(7'h01, 3'd5), 1'b0, 2'b10, 32'h1234_5678, 32'd0);
      run_op("remu0",    mk_r(7'h01, 3'd7), 1'b0, 2'b10, 32'd9, 32'd0);
      run_op("sub",      mk_r(7'h20, 3'd0), 1'b0, 2'b10, 32'd10, 32'd25);
      run_op("add_zero", mk_r(7'h00, 3'd0), 1'b0, 2'b10, 32'd7, m - 32'd6);
      run_op("sll",      mk_r(7'h00, 3'd1), 1'b0, 2'b10, 32'd3, 32'(width() + 2));
      run_op("xor",      mk_r(7'h00, 3'd4), 1'b0, 2'b10, 32'hA5A5_5A5A, 32'h0FF0_F00F);
      run_op("or",       mk_r(7'h00, 3'd6), 1'b0, 2'b10, 32'hA5A5_5A5A, 32'h0FF0_F00F);
      run_op("and",      mk_r(7'h00, 3'd7), 1'b0, 2'b10, 32'hA5A5_5A5A, 32'h0FF0_F00F);
      run_op("srai",     mk_i({7'h20, 5'd3}, 3'd5, 7'h13), 1'b1, 2'b10, msb, 32'd0);
      run_op("load",     mk_i(12'h800, 3'd2, 7'h03), 1'b1, 2'b10, 32'h1000, 32'd0);
      run_op("store",    mk_s(12'h7FF), 1'b1, 2'b10, 32'd1, 32'd0);
      run_op("branch",   mk_b(13'h1FF0), 1'b0, 2'b10, 32'd77, 32'd77);
      run_op("ill_opc",  32'h0000_0037, 1'b0, 2'b10, 32'd3, 32'd4);
      run_op("ill_mop",  mk_r(7'h01, 3'd1), 1'b0, 2'b10, 32'd3, 32'd4);
      run_op("oper11",   mk_r(7'h00, 3'd0), 1'b0, 2'b11, 32'd3, 32'd4);
      run_op("oper01",   mk_i(12'h005, 3'd0, 7'h13), 1'b1, 2'b01, 32'd3, 32'd0);

      // Output stall, then simultaneous retire and accept.
      idle(2);
      present("hold", mk_r(7'h00, 3'd4), 1'b0, 2'b10, 32'h0000_1234, 32'h0000_00FF, 1'b0);
      collect();
      held = exp_res;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold/result", o_result, held);
         chk("hold/out_valid", 32'(o_valid), 32'd1);
         chk("hold/in_ready", 32'(o_ready), 32'd0);
      end
      present("both", mk_r(7'h00, 3'd0), 1'b0, 2'b10, 32'd40, 32'd2, 1'b1);
      collect();

      // Reset in the middle of an iterative divide.
      run_op("pre_rst", mk_r(7'h00, 3'd0), 1'b0, 2'b01, 32'd50, 32'd8);
      prev = exp_res;
      present("rst_div", mk_r(7'h01, 3'd5), 1'b0, 2'b10, 32'd1000, 32'd7, 1'b1);
      @(posedge clk);
      #1;
      d_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("busy/out_valid", 32'(o_valid), 32'd0);
      chk("busy/result", o_result, prev);
      chk("busy/in_ready", 32'(o_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst/out_valid", 32'(o_valid), 32'd0);
      chk("rst/result", o_result, 32'd0);
      chk("rst/is_zero", 32'(o_zero), 32'd0);
      chk("rst/in_ready", 32'(o_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", mk_r(7'h01, 3'd5), 1'b0, 2'b00, 32'd1, 32'd1);

      for (int i = 0; i < 25; i++) begin
         logic [31:0] ins, a, b;
         logic [1:0]  oper;
         logic [6:0]  f7;
         case ($urandom_range(0, 5))
            0: begin
               case ($urandom_range(0, 2))
                  0: f7 = 7'h00;
                  1: f7 = 7'h20;
                  default: f7 = 7'h01;
               endcase
               ins = mk_r(f7, 3'($urandom));
            end
            1: ins = mk_i(12'($urandom), 3'($urandom), 7'h13);
            2: ins = mk_i(12'($urandom), 3'd2, 7'h03);
            3: ins = mk_s(12'($urandom));
            4: ins = mk_b(13'($urandom));
            default: ins = $urandom;
         endcase
         oper = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
         a    = $urandom;
         b    = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         run_op("rnd", ins, (ins[6:0] == 7'h33) ? 1'b0 : 1'($urandom), oper, a, b);
      end
   endtask

   initial begin
      sel      = 1'b0;
      rst_n    = 1'b0;
      d_valid  = 1'b0;
      d_src    = 1'b0;
      d_oready = 1'b1;
      d_instr  = '0;
      d_oper   = '0;
      d_rs1    = '0;
      d_rs2    = '0;
      #12;
      chk("reset/out_valid", 32'(o_valid), 32'd0);
      chk("reset/result", o_result, 32'd0);
      chk("reset/is_zero", 32'(o_zero), 32'd0);
      chk("reset/illegal", 32'(o_ill), 32'd0);
      chk("reset/in_ready", 32'(o_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      run_suite();

      idle(2);
      sel = 1'b1;
      idle(1);
      run_suite();

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multicycle_exec_unit.md
# multicycle_exec_unit

Parametrised execute stage for the RISC-V subset core: decodes the immediate and ALU operation from the instruction word, executes RV32I-style integer ops in one cycle, and executes MUL/MULHU/DIVU/REMU iteratively over XLEN cycles. The block sits between register read and writeback and uses a valid/ready handshake on both sides, so the pipeline stalls while a multiply or divide is in flight. It generalises the earlier single-cycle ALU: it adds width parametrisation, shift/compare/xor ops, M-extension ops and flow control.

## Interface
- XLEN, 32, datapath width; must be a power of two, at least 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept; transfer occurs when in_valid && in_ready.
- instruction  in  32  instruction word; fields opcode [6:0], funct3 [14:12], funct7 [31:25].
- alu_src  in  1  0: operand2 = rs2_val; 1: operand2 = ext_imm.
- alu_oper  in  2  00 add, 01 sub, 10 decode from instruction, 11 reserved (result 0).
- rs1_val, rs2_val  in  XLEN  source operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready.
- result  out  XLEN  registered result.
- is_zero  out  1  registered (result == 0).
- illegal  out  1  registered; set for an unsupported decode.
- ext_imm  out  XLEN  combinational sign-extended immediate of the current instruction.

## Operation
- Immediate: bit 31 is replicated into bits XLEN-1..12. Opcode 0010011/0000011 uses I-type, imm[11:0] = instr[31:20]. Opcode 0100011 uses S-type. Opcode 1100011 uses B-type with imm[0] = 0. All other opcodes give 0.
- When alu_oper = 10 and opcode is 0010011 or 0110011 with funct7 != 0000001, funct3 selects the op:
  - 000: add; sub only for R-type with funct7[5] = 1.
  - 001: sll. 010: slt (signed). 011: sltu. 100: xor. 110: or. 111: and.
  - 101: srl, or sra when funct7[5] = 1.
- Shift amount is operand2[log2(XLEN)-1:0].
- alu_oper = 10 with opcode 0000011/0100011 gives add; with opcode 1100011 gives sub.
- Opcode 0110011 with funct7 = 0000001:
  - funct3 000: MUL, low XLEN bits of the product.
  - 011: MULHU, high XLEN bits of the unsigned product.
  - 101: DIVU. 111: REMU.
  - Other funct3 values: illegal = 1, result 0.
- Any other alu_oper = 10 decode: illegal = 1, result 0.
- FSM states are IDLE, BUSY and DONE.
  - IDLE, accept of a single-cycle op: go to DONE, latching result, is_zero and illegal.
  - IDLE, accept of MUL/MULHU/DIVU/REMU: load the operands, clear a 2*XLEN accumulator, set count = XLEN, go to BUSY.
  - BUSY: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; count decrements. At count = 1 the final step is performed and the state goes to DONE with the result latched.
  - DONE: out_valid = 1. On out_ready, go to IDLE, or take the next op if in_valid.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Divide by zero takes no iterations and goes directly to DONE. DIVU returns all ones; REMU returns rs1_val.
- Operands are captured at accept. Input changes during BUSY or DONE have no effect.

## Timing
- Reset state: state IDLE, out_valid 0, result 0, is_zero 0, illegal 0, count 0, accumulator 0. in_ready is 1 after reset.
- Assertion of rst_n at any time, including mid-BUSY, takes effect immediately and discards the operation in flight.
- Single-cycle op accepted at edge N: out_valid is high from N+1.
- Iterative op accepted at edge N: out_valid is high from N+XLEN+1.
- Divide by zero accepted at edge N: out_valid is high from N+1.
- While out_ready = 0, out_valid and result hold unchanged indefinitely.
- Back-to-back single-cycle ops with out_ready held at 1 sustain one result per cycle.
- Simultaneous output accept and input accept in DONE: the new op is taken at that edge and the old result is retired.

## Test plan
- XLEN = 32, addi x, rs1 = 5, imm = -3, alu_src = 1, alu_oper = 10 -> result 2 one cycle after accept, is_zero 0; ext_imm = 0xFFFFFFFD.
- sra, rs1 = 0x80000000, rs2 = 4 -> 0xF8000000; srl with the same operands -> 0x08000000; sltu 1 vs 0xFFFFFFFF -> 1; slt with the same operands -> 0.
- MULHU, rs1 = rs2 = 0xFFFFFFFF -> 0xFFFFFFFE exactly 33 cycles after accept; MUL with the same operands -> 0x00000001.
- DIVU 100/7 -> 14 and REMU 100/7 -> 2, each at 33 cycles. DIVU x/0 -> 0xFFFFFFFF and REMU 9/0 -> 9, each at 1 cycle.
- Hold out_ready = 0 for 5 cycles after DONE -> result stable and in_ready = 0. Raise out_ready together with a new in_valid -> both transfers occur on the same edge.
- Assert rst_n low at cycle 10 of a DIVU -> outputs cleared immediately. After release, an add of 1 + 1 -> 2 at accept + 1. Also re-run the test set at XLEN = 16 with the cycle count adjusted to 17.
